// File: rtl/reg_window_ctrl_if.sv
// rtl/reg_window_ctrl_if.sv - decode/register-file bus for the register-window unit
//
// Purpose: bundles the decode-side requests and the register-file-side
// address/move controls of reg_window_ctrl.
// Modports:
//   master - decode/test side: drives rel_*, *_wen_in, call, rtn, call_off,
//            fault_clr; observes everything else.
//   slave  - reg_window_ctrl: consumes the requests, drives addresses,
//            gated enables, window-move controls, FP, stack status, fault.
interface reg_window_ctrl_if;
  logic [2:0] rel_rd;
  logic [2:0] rel_rs;
  logic [2:0] rel_rm;
  logic       rd_wen_in;
  logic       rs_wen_in;
  logic       call;
  logic       rtn;
  logic [2:0] call_off;
  logic       fault_clr;

  logic [6:0] rd_addr;
  logic [6:0] rs_addr;
  logic [6:0] rm_addr;
  logic [2:0] actual_rd;
  logic [2:0] actual_rs;
  logic [2:0] actual_rm;
  logic       rd_wen;
  logic       rs_wen;
  logic [6:0] new_fp;
  logic       fp_move;
  logic       fp_push_up;
  logic [6:0] fp;
  logic       stk_empty;
  logic       stk_full;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output rel_rd, rel_rs, rel_rm, rd_wen_in, rs_wen_in,
           call, rtn, call_off, fault_clr,
    input  rd_addr, rs_addr, rm_addr, actual_rd, actual_rs, actual_rm,
           rd_wen, rs_wen, new_fp, fp_move, fp_push_up, fp,
           stk_empty, stk_full, fault, fault_code
  );

  modport slave (
    input  rel_rd, rel_rs, rel_rm, rd_wen_in, rs_wen_in,
           call, rtn, call_off, fault_clr,
    output rd_addr, rs_addr, rm_addr, actual_rd, actual_rs, actual_rm,
           rd_wen, rs_wen, new_fp, fp_move, fp_push_up, fp,
           stk_empty, stk_full, fault, fault_code
  );
endinterface

// File: rtl/reg_window_ctrl.sv
// rtl/reg_window_ctrl.sv - frame pointer and register-window address unit
//
// Purpose: holds the frame pointer for a 128-entry windowed register file,
// maps 3-bit window-relative register numbers to 7-bit absolute addresses,
// sequences CALL/RTN window moves with a return stack of call offsets, and
// flags illegal moves through a sticky fault.
// Ports:
//   i_clk    - clock, all state updates on the rising edge
//   i_rst_n  - asynchronous active-low reset
//   io_win   - reg_window_ctrl_if.slave: decode requests in; addresses,
//              gated write enables, New_FP/FP_move/FP_push_up, FP,
//              stack status and Fault/Fault_Code out
module reg_window_ctrl #(
  parameter int NREGS       = 128,
  parameter int WIN         = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  reg_window_ctrl_if.slave   io_win
);
  localparam int              PW       = $clog2(STACK_DEPTH);
  localparam int              CW       = $clog2(STACK_DEPTH + 1);
  localparam logic [7:0]      FP_MAX   = 8'(NREGS - WIN);
  localparam logic [CW-1:0]   CNT_FULL = CW'(STACK_DEPTH);

  logic [6:0]    r_fp;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_stk [STACK_DEPTH];
  logic          r_fault;
  logic [1:0]    r_fault_code;

  logic          w_empty;
  logic          w_full;
  logic [PW-1:0] w_top_idx;
  logic [2:0]    w_top;
  logic [7:0]    w_call_sum;
  logic          w_call_ok;
  logic          w_rtn_ok;
  logic          w_reject;
  logic [1:0]    w_code;
  logic [6:0]    w_new_fp;
  logic          w_move;
  logic          w_push_up;
  logic [2:0]    w_act_rs;
  logic          w_rd_wen;
  logic          w_rs_wen;

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == CNT_FULL);
  assign w_top_idx  = PW'(r_cnt - CW'(1));
  assign w_top      = r_stk[w_top_idx];
  // One bit wider than FP so the range test sees the true sum.
  assign w_call_sum = {1'b0, r_fp} + {5'b0, io_win.call_off};

  assign w_call_ok = io_win.call & ~io_win.rtn & (io_win.call_off != 3'd0) &
                     (w_call_sum <= FP_MAX) & ~w_full;
  assign w_rtn_ok  = io_win.rtn & ~io_win.call & ~w_empty;
  assign w_reject  = (io_win.call | io_win.rtn) & ~w_call_ok & ~w_rtn_ok;

  // Cause priority: conflict, then offset/range, then full, then empty.
  always_comb begin
    w_code = 2'd3;
    if (io_win.call && io_win.rtn)
      w_code = 2'd3;
    else if (io_win.call && ((io_win.call_off == 3'd0) || (w_call_sum > FP_MAX)))
      w_code = 2'd1;
    else if (io_win.call)
      w_code = 2'd2;
  end

  always_comb begin
    w_new_fp  = r_fp;
    w_move    = 1'b0;
    w_push_up = 1'b0;
    w_act_rs  = io_win.rel_rs;
    w_rd_wen  = io_win.rd_wen_in;
    w_rs_wen  = io_win.rs_wen_in;
    if (w_call_ok) begin
      // Link write goes to the caller's window, so Rd stays enabled.
      w_new_fp = w_call_sum[6:0];
      w_move   = 1'b1;
      w_act_rs = io_win.call_off;
      w_rs_wen = 1'b0;
    end else if (w_rtn_ok) begin
      w_new_fp  = r_fp - {4'b0, w_top};
      w_move    = 1'b1;
      w_push_up = 1'b1;
      w_act_rs  = w_top;
      w_rd_wen  = 1'b0;
      w_rs_wen  = 1'b0;
    end else if (io_win.call || io_win.rtn) begin
      w_rd_wen = 1'b0;
      w_rs_wen = 1'b0;
    end
    // Keep the file quiet while reset is held.
    if (!i_rst_n) begin
      w_new_fp = 7'd0;
      w_move   = 1'b0;
      w_rd_wen = 1'b0;
      w_rs_wen = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fp  <= 7'd0;
      r_cnt <= '0;
    end else if (w_call_ok) begin
      r_fp  <= w_new_fp;
      r_cnt <= r_cnt + CW'(1);
    end else if (w_rtn_ok) begin
      r_fp  <= w_new_fp;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Stack contents need no reset: the count alone defines validity.
  always_ff @(posedge i_clk) begin
    if (w_call_ok)
      r_stk[r_cnt[PW-1:0]] <= io_win.call_off;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fault      <= 1'b0;
      r_fault_code <= 2'd0;
    end else if (w_reject) begin
      r_fault <= 1'b1;
      // First cause is kept; a same-cycle clear lets the new cause in.
      if (!r_fault || io_win.fault_clr)
        r_fault_code <= w_code;
    end else if (io_win.fault_clr) begin
      r_fault      <= 1'b0;
      r_fault_code <= 2'd0;
    end
  end

  assign io_win.rd_addr    = r_fp + {4'b0, io_win.rel_rd};
  assign io_win.rs_addr    = r_fp + {4'b0, io_win.rel_rs};
  assign io_win.rm_addr    = r_fp + {4'b0, io_win.rel_rm};
  assign io_win.actual_rd  = io_win.rel_rd;
  assign io_win.actual_rs  = w_act_rs;
  assign io_win.actual_rm  = io_win.rel_rm;
  assign io_win.rd_wen     = w_rd_wen;
  assign io_win.rs_wen     = w_rs_wen;
  assign io_win.new_fp     = w_new_fp;
  assign io_win.fp_move    = w_move;
  assign io_win.fp_push_up = w_push_up;
  assign io_win.fp         = r_fp;
  assign io_win.stk_empty  = w_empty;
  assign io_win.stk_full   = w_full;
  assign io_win.fault      = r_fault;
  assign io_win.fault_code = r_fault_code;
endmodule

// File: doc/reg_window_ctrl.md
# reg_window_ctrl

Frame-pointer and register-window address unit sitting directly upstream of the 128-entry windowed register file. It holds the current frame pointer (FP), turns 3-bit window-relative register numbers from decode into 7-bit absolute register-file addresses, and sequences CALL/RTN window moves. It drives the file's move controls (New_FP, FP_move, FP_push_up) and keeps a return stack of call offsets. It rejects illegal moves and reports them through a sticky fault.

## Interface
- NREGS, 128: register-file depth; all addresses are 7 bits.
- WIN, 8: window size.
- STACK_DEPTH, 16: return-stack entries, each 3 bits.
- Clock  in  1: single clock; all state updates on the rising edge.
- Reset_n  in  1: asynchronous, active-low reset.
- Rel_Rd, Rel_Rs, Rel_Rm  in  3 each: window-relative register numbers from decode.
- Rd_Wen_in, Rs_Wen_in  in  1 each: decode write requests.
- Call  in  1: CALL this cycle; Rd_Data on the file side carries the link value.
- Rtn  in  1: RTN this cycle.
- Call_Off  in  3: window shift I for CALL; legal range 1..7.
- Fault_Clr  in  1: clears Fault and Fault_Code.
- Rd_Addr, Rs_Addr, Rm_Addr  out  7 each: absolute addresses, FP + Rel_x.
- Actual_Rd, Actual_Rs, Actual_Rm  out  3 each: relative numbers forwarded to the file. Actual_Rs carries the move offset during an accepted CALL or RTN.
- Rd_Wen, Rs_Wen  out  1 each: gated write enables.
- New_FP  out  7: FP value after the current cycle.
- FP_move, FP_push_up  out  1 each: window-move controls.
- FP  out  7: current frame pointer (registered).
- Stk_Empty, Stk_Full  out  1 each: return-stack status.
- Fault  out  1: sticky error flag (registered).
- Fault_Code  out  2: cause of the first fault. 1 = FP range/offset, 2 = stack overflow, 3 = stack underflow/conflict.

## Operation
- **Idle cycle** (no Call, no Rtn):
  - x_Addr = FP + Rel_x, in 7-bit arithmetic.
  - Rd_Wen = Rd_Wen_in; Rs_Wen = Rs_Wen_in.
  - FP_move = 0; New_FP = FP.
- **Accepted CALL.** Accept when all of: Call=1, Rtn=0, Call_Off != 0, FP + Call_Off <= NREGS-WIN (120), and the stack is not full.
  - Outputs this cycle: New_FP = FP + Call_Off; FP_move = 1; FP_push_up = 0; Actual_Rs = Call_Off.
  - Rd_Wen = Rd_Wen_in, with Rd_Addr computed from the old FP. The link is written into the caller's window.
  - Rs_Wen is forced to 0.
  - At the edge: push Call_Off, then FP <= New_FP.
- **Accepted RTN.** Accept when Rtn=1, Call=0 and the stack is not empty. Let top = the top stack entry.
  - Outputs this cycle: New_FP = FP - top; FP_move = 1; FP_push_up = 1; Actual_Rs = top.
  - Rd_Wen and Rs_Wen are forced to 0.
  - At the edge: pop, then FP <= New_FP.
- **Rejected Call or Rtn** (any acceptance condition fails):
  - FP_move = 0, Rd_Wen = 0, Rs_Wen = 0. FP and the stack are unchanged.
  - At the edge, Fault <= 1 and Fault_Code is set with this priority: Call and Rtn both high → 3; bad offset or range → 1; full → 2; empty → 3.
- Fault_Code holds the first cause until cleared; later faults do not overwrite it.
- Fault_Clr clears both registers at the edge. If Fault_Clr and a new fault occur in the same cycle, the new fault wins.
- FP is never outside 0..120. Address sums wrap modulo 128, which cannot occur in a legal window.
- Stack: array with a pointer, count 0..STACK_DEPTH. Stk_Empty = (count == 0); Stk_Full = (count == STACK_DEPTH). Both are combinational from the registered count.

## Timing
- Reset (Reset_n low, asynchronous):
  - FP = 0, count = 0, Fault = 0, Fault_Code = 0.
  - While Reset_n is low: Rd_Wen, Rs_Wen and FP_move are forced to 0, and New_FP = 0.
- Address, enable and move outputs are combinational from the inputs and registered state, with zero latency, so the register file samples them on the same edge.
- FP, the stack and Fault update at the rising edge. A new window is usable by the instruction in the next cycle.
- Back-to-back CALL, CALL, RTN, RTN on consecutive cycles is legal; each cycle uses the FP and stack top as updated at the previous edge.
- Reset asserted mid-sequence discards the stack and FP immediately, with no completion of the pending edge.

## Test plan
- **Reset and idle addressing.** Reset, then Rel_Rd=5, Rd_Wen_in=1 → Rd_Addr=5, Rd_Wen=1, FP_move=0, FP=0, Stk_Empty=1.
- **CALL.** FP=0, Call_Off=3, Rel_Rd=7, Rd_Wen_in=1 → New_FP=3, Rd_Addr=7, Actual_Rs=3, FP_push_up=0. Next cycle FP=3 and Rel_Rm=2 → Rm_Addr=5.
- **Nested call and return.** CALL 4, CALL 2, RTN, RTN → FP goes 4, 6, 4, 0. The RTN cycles show New_FP=4 then 0, with FP_push_up=1 and Rd_Wen=0; Stk_Empty=1 at the end.
- **Range limit.** With FP=118, CALL 3 → rejected: FP stays 118, Rd_Wen=0, Fault=1, Fault_Code=1. With FP=117, CALL 3 → accepted, FP=120.
- **Stack limits.**
  - Sixteen CALL 1 → FP=16, Stk_Full=1.
  - A 17th CALL is rejected with Fault_Code=2.
  - Fault_Clr → Fault=0.
  - Sixteen RTN, then one more → Fault_Code=3, FP=0.
- **Conflict and reset.** Call=Rtn=1 → no FP_move, Fault_Code=3. Assert Reset_n mid-sequence with FP=9 → FP=0 and Fault=0 immediately, with no clock edge needed.
